// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: radix-2 shift-add multiply,
// restoring divide, one iteration per cycle, results committed to architectural HI/LO.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             sinSigno,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [CNT_W-1:0]   counter;
    logic               op_div;
    logic               neg_a;
    logic               neg_b;
    logic               b_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    // Multiply: {product high, multiplier/product low}. Divide: low half shifts dividend out, quotient in.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;

    logic               in_neg_a;
    logic               in_neg_b;
    logic [WIDTH-1:0]   in_mag_a;
    logic [WIDTH-1:0]   in_mag_b;

    assign in_neg_a = !sinSigno && operand_a[WIDTH-1];
    assign in_neg_b = !sinSigno && operand_b[WIDTH-1];
    assign in_mag_a = in_neg_a ? (~operand_a + 1'b1) : operand_a;
    assign in_mag_b = in_neg_b ? (~operand_b + 1'b1) : operand_b;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH+1:0]   shifted;
    logic [WIDTH+1:0]   diff;
    logic               fits;

    assign add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    assign shifted = {rem, acc[WIDTH-1]};
    assign diff    = shifted - {2'b00, b_mag};
    // Borrow out of the trial subtraction means the divisor did not fit.
    assign fits    = !diff[WIDTH+1];

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign prod_fix = (neg_a ^ neg_b) ? (~acc + 1'b1) : acc;
    assign quo_fix  = (neg_a ^ neg_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    assign rem_fix  = neg_a ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            op_div      <= 1'b0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            b_zero      <= 1'b0;
            a_raw       <= '0;
            a_mag       <= '0;
            b_mag       <= '0;
            acc         <= '0;
            rem         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !kill) begin
                        op_div  <= is_div;
                        neg_a   <= in_neg_a;
                        neg_b   <= in_neg_b;
                        b_zero  <= (operand_b == '0);
                        a_raw   <= operand_a;
                        a_mag   <= in_mag_a;
                        b_mag   <= in_mag_b;
                        acc     <= {{WIDTH{1'b0}}, (is_div ? in_mag_a : in_mag_b)};
                        rem     <= '0;
                        counter <= '0;
                        state   <= CALC;
                        busy    <= 1'b1;
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (op_div) begin
                            rem <= fits ? diff[WIDTH:0] : shifted[WIDTH:0];
                            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], fits};
                        end else begin
                            acc <= {add_sum, acc[WIDTH-1:1]};
                        end
                        counter <= counter + 1'b1;
                        if (counter == CNT_W'(WIDTH - 1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!kill) begin
                        done <= 1'b1;
                        if (!op_div) begin
                            hi          <= prod_fix[2*WIDTH-1:WIDTH];
                            lo          <= prod_fix[WIDTH-1:0];
                            div_by_zero <= 1'b0;
                        end else if (b_zero) begin
                            hi          <= a_raw;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi          <= rem_fix;
                            lo          <= quo_fix;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage. Consumes the ID/EX pipeline register outputs: operand A is Read_Data_1_EX, operand B is Read_Data_2_EX, signedness comes from sinSigno_EX.
- Computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
- Holds a stall to the front end while it is computing.
- Supports a flush kill when a branch or jump resolves in EX.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- start  input  1  single-cycle issue pulse from EX decode.
- is_div  input  1  1 = divide, 0 = multiply.
- sinSigno  input  1  1 = unsigned (MULTU/DIVU), 0 = signed.
- operand_a  input  WIDTH  multiplicand / dividend.
- operand_b  input  WIDTH  multiplier / divisor.
- kill  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  stall request to the PC, IF/ID and ID/EX registers.
- done  output  1  one-cycle pulse; HI/LO are updated in this cycle.
- div_by_zero  output  1  sticky flag for the last completed operation.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, busy=0, done=0, div_by_zero=0, hi=0, lo=0. All internal operand and accumulator registers are cleared.
- FSM states are IDLE, CALC, FIX. busy is registered and equals (state==CALC || state==FIX).
- IDLE:
  - start=1 and kill=0 at a clock edge: latch operation type and signedness.
  - Latch magnitudes |a| and |b| when signed, raw values when unsigned.
  - Record result sign(s); for divide, record whether the divisor is zero.
  - counter <- 0, go to CALC.
- CALC, one iteration per cycle for exactly WIDTH cycles; counter increments each cycle and the FSM goes to FIX when counter==WIDTH-1.
  - Multiply: radix-2 shift-add into a 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract. The remainder register is WIDTH+1 bits.
- FIX, one cycle:
  - Multiply: apply sign correction (two's complement negate of the 2*WIDTH product) when signed and the operand signs differ.
  - Divide: quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - hi/lo are written at the FIX->IDLE edge. done=1 in the following cycle (first IDLE cycle); busy=0 in that same cycle.
- Latency: start sampled at edge N gives busy=1 from after edge N and done=1 after edge N+WIDTH+1. With WIDTH=32, busy is high for 33 cycles.
- Signed multiply result is the full 64-bit product: hi = upper WIDTH bits, lo = lower WIDTH bits.
- Divide by zero: lo = all ones, hi = operand_a as originally supplied, div_by_zero=1. Full latency still applies.
- Signed overflow: 0x80000000 / -1 gives lo=0x80000000, hi=0, with no flag.
- div_by_zero updates only at completion of a divide. It is cleared on completion of any non-faulting operation.
- start while busy: ignored; the upstream stall guarantees this does not occur.
- start on the done cycle: accepted, and a new operation begins.
- kill in CALC or FIX: the FSM returns to IDLE at the next edge. hi, lo and div_by_zero are unchanged, and no done is generated.
- kill with start in IDLE: kill wins and the operation is not accepted.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0.
- hi/lo hold their value between operations. MFHI/MFLO read them combinationally outside this block.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF, start at edge 0 -> busy for 33 cycles; done after edge 33; hi=0xFFFFFFFE, lo=0x00000001.
- Signed MULT -3 * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Signed DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF (remainder -1).
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1. A following MULTU 2*3 clears div_by_zero; hi=0, lo=6.
- Signed DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Start MULTU 5*5, assert kill at cycle 10 -> busy=0 next cycle; no done pulse; hi/lo keep their prior values. Then start and kill asserted together in IDLE -> busy stays 0.
- Start DIVU, drive reset=0 asynchronously mid-CALC -> busy, done, hi, lo and div_by_zero go to 0 immediately without waiting for clk. After release, a new DIVU 9/4 gives lo=2, hi=1.
